// File: rtl/code42_prio_enc_if.sv
// Request/result bundle for code42_prio_enc.
//   I   : request vector, bit N_IN-1 has the highest priority
//   en  : encode enable
//   F   : registered index of the highest set request bit
//   vld : registered "en and any request set"
//   err : registered "en and more than one request set"
// The master drives requests and observes results; the slave is the encoder.
interface code42_prio_enc_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_OUT = 2
);
  logic [N_IN-1:0]  I;
  logic             en;
  logic [W_OUT-1:0] F;
  logic             vld;
  logic             err;

  modport master (
    output I, en,
    input  F, vld, err
  );

  modport slave (
    input  I, en,
    output F, vld, err
  );
endinterface

// File: rtl/code42_prio_enc.sv
// Registered 4-to-2 priority encoder with enable.
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous active-high reset, clears F/vld/err and overrides en/I
//   bus : code42_prio_enc_if slave modport (I, en in; F, vld, err out)
// Outputs reflect I and en sampled one edge earlier; there is no
// combinational path from inputs to outputs.
module code42_prio_enc #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_OUT = 2
) (
  input  logic               clk,
  input  logic               rst,
  code42_prio_enc_if.slave   bus
);

  localparam int unsigned CW = $clog2(N_IN + 1);

  logic [W_OUT-1:0] f_next;
  logic             vld_next;
  logic             err_next;
  logic [CW-1:0]    ones;

  // Everything is gated behind en so that unknown request bits while
  // disabled cannot reach the registers.
  always_comb begin
    f_next   = '0;
    vld_next = 1'b0;
    err_next = 1'b0;
    ones     = '0;
    if (bus.en) begin
      // Ascending scan: the last set bit seen is the highest index.
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (bus.I[i]) begin
          f_next = W_OUT'(i);
          ones   = ones + CW'(1);
        end
      end
      vld_next = (ones != '0);
      err_next = (ones > CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.F   <= '0;
      bus.vld <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.F   <= f_next;
      bus.vld <= vld_next;
      bus.err <= err_next;
    end
  end

endmodule

// File: tb/tb_code42_prio_enc.sv
module tb_code42_prio_enc;

  logic clk;
  logic rst;

  code42_prio_enc_if #(.N_IN(4), .W_OUT(2)) bus ();

  code42_prio_enc #(.N_IN(4), .W_OUT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] i;
    logic [1:0] f;
    logic       v;
    logic       e;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic en, input logic [3:0] i,
                              input logic [1:0] f, input logic v, input logic e);
    vec_t t;
    t.rst = r; t.en = en; t.i = i; t.f = f; t.v = v; t.e = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [1:0] f,
                       input logic v, input logic e);
    n_cmp++;
    if (bus.F !== f || bus.vld !== v || bus.err !== e) begin
      n_fail++;
      $display("FAIL %s: got F=%0d vld=%0b err=%0b, want F=%0d vld=%0b err=%0b",
               name, bus.F, bus.vld, bus.err, f, v, e);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [3:0] i);
    rst    = r;
    bus.en = en;
    bus.I  = i;
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'hF);

    // Each entry: inputs applied before an edge, expected outputs after it.
    vecs.push_back(mk(1, 1, 4'hF, 2'd0, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 2'd0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h8, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 2'd0, 1, 0));
    vecs.push_back(mk(0, 1, 4'h2, 2'd1, 1, 0));
    vecs.push_back(mk(0, 1, 4'h4, 2'd2, 1, 0));
    vecs.push_back(mk(0, 1, 4'h8, 2'd3, 1, 0));
    vecs.push_back(mk(0, 1, 4'h7, 2'd2, 1, 1));
    vecs.push_back(mk(0, 1, 4'hF, 2'd3, 1, 1));
    vecs.push_back(mk(0, 1, 4'h0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h8, 2'd3, 1, 0));
    vecs.push_back(mk(0, 0, 4'h8, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h4, 2'd2, 1, 0));
    vecs.push_back(mk(1, 1, 4'h4, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'h4, 2'd2, 1, 0));
    vecs.push_back(mk(0, 1, 4'h3, 2'd1, 1, 1));
    vecs.push_back(mk(0, 1, 4'h5, 2'd2, 1, 1));
    vecs.push_back(mk(0, 1, 4'hA, 2'd3, 1, 1));
    vecs.push_back(mk(0, 1, 4'h6, 2'd2, 1, 1));
    vecs.push_back(mk(0, 1, 4'h9, 2'd3, 1, 1));
    vecs.push_back(mk(0, 0, 4'hF, 2'd0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].i);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].f, vecs[k].v, vecs[k].e);
    end

    // Outputs must hold between edges even when inputs change.
    drive(1'b0, 1'b1, 4'h8);
    @(posedge clk); #1;
    check("hold_pre", 2'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'h1);
    #2;
    check("no_comb_path", 2'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0);
    #1;
    check("no_comb_path_en", 2'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4'h1);
    @(posedge clk); #1;
    check("hold_post", 2'd0, 1'b1, 1'b0);

    // Reset mid-stream, then release with en low: still idle until en rises.
    drive(1'b0, 1'b1, 4'hE);
    @(posedge clk); #1;
    check("pre_rst", 2'd3, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 4'hE);
    @(posedge clk); #1;
    check("mid_rst", 2'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'hE);
    @(posedge clk); #1;
    check("post_rst_en0", 2'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hE);
    @(posedge clk); #1;
    check("first_encode", 2'd3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
